instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Boot-time instruction loader that sits directly upstream of the single-cycle MIPS core.
- Accepts a byte stream from a host link (UART receiver or testbench) over a valid/ready handshake and assembles it into 32-bit instruction words.
- Drives the core's instruction-memory write port and holds the core in reset until the program image is fully written.
- The core's instruction write clock is tied to the same clock_in; this block produces single-cycle write strobes.

Parameters:
- BASE_ADDRESS, 32'h0000_0000, byte address of the first instruction word written.
- MAX_WORDS, 256, maximum accepted word count; larger counts are rejected.
- ADDRESS_WIDTH, 32, width of instr_address_out.

Ports:
- clock_in  input  1  system clock; all state updates on the rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle pulse; begins a load (honoured in IDLE, DONE and ERROR only).
- byte_in  input  8  incoming stream byte.
- byte_valid_in  input  1  byte_in is valid this cycle.
- byte_ready_out  output  1  loader accepts byte_in this cycle; a transfer occurs when valid & ready.
- instrWrite_out  output  1  instruction-memory write strobe, one cycle per word.
- instr_address_out  output  ADDRESS_WIDTH  word write address.
- instr_out  output  32  word write data.
- cpu_reset_out  output  1  1 = hold core in reset.
- done_out  output  1  load completed successfully.
- error_out  output  1  word count exceeded MAX_WORDS.
- words_loaded_out  output  16  number of words written in the current or last load.

Behaviour:
- Reset (reset_in = 0, asynchronous):
  - State = IDLE.
  - byte_ready_out = 0, instrWrite_out = 0, instr_address_out = BASE_ADDRESS, instr_out = 0.
  - cpu_reset_out = 1, done_out = 0, error_out = 0, words_loaded_out = 0.
  - Byte counter and word count are cleared.
- Frame format:
  - 4-byte word count N, most significant byte first.
  - Followed by N instruction words, 4 bytes each, most significant byte first.
- States:
  - IDLE: ready = 0, cpu_reset_out = 1. start_in -> COUNT, clearing the byte counter, words_loaded_out and the address.
  - COUNT: ready = 1. Each transfer shifts the byte into the count register (count <= {count[23:0], byte}).
    - On the 4th transfer: N = 0 -> DONE; N > MAX_WORDS -> ERROR; otherwise -> DATA.
  - DATA: ready = 1. Each transfer shifts into the word register.
    - On the 4th transfer -> WRITE. The byte counter wraps from 3 to 0.
  - WRITE: lasts exactly one cycle.
    - ready = 0, instrWrite_out = 1.
    - instr_out = the assembled word; instr_address_out = BASE_ADDRESS + 4*words_loaded_out (value before increment).
    - Next edge: words_loaded_out increments; if the new value == N -> DONE, else -> DATA.
    - Address and data remain stable through the strobe cycle; they are only updated when entering WRITE.
  - DONE: ready = 0, cpu_reset_out = 0, done_out = 1. start_in -> COUNT; the same edge reasserts cpu_reset_out and clears done_out.
  - ERROR: ready = 0, cpu_reset_out = 1, error_out = 1. start_in -> COUNT and clears error_out.
- Timing and boundary rules:
  - Latency: the write strobe is asserted the cycle after the 4th byte of a word is accepted. Throughput is one word per 5 cycles with byte_valid_in held high.
  - Stalls: byte_valid_in low stalls without state change. No timeout; partial words are retained indefinitely.
  - start_in is ignored in COUNT, DATA and WRITE (no abort mid-load). A bus abort is performed via reset_in only.
  - Reset mid-load returns to IDLE with the core held in reset. Partially written memory contents are not cleared.
  - Address arithmetic is modulo 2^ADDRESS_WIDTH, with no wrap check. N = MAX_WORDS is accepted.
  - byte_ready_out is a registered, state-decoded output: it is high in COUNT and DATA only, and never high in the same cycle as instrWrite_out.
  - All outputs are registered or decoded from state only. There is no combinational path from byte_valid_in to any output.

Test Plan:
- Reset then idle: release reset with no start -> cpu_reset_out = 1, ready = 0, done_out = 0 for 20 cycles.
- Two-word load: start, bytes 00 00 00 02, 20 08 00 05, 8C 09 00 04 -> two strobes: (addr 0x0, data 0x20080005), then (addr 0x4, data 0x8C090004), each strobe the cycle after the word's 4th byte. Then done_out = 1, cpu_reset_out = 0, words_loaded_out = 2.
- Zero count and overflow:
  - Count 00 00 00 00 -> DONE with no strobes.
  - Count 00 00 01 01 with MAX_WORDS = 256 -> error_out = 1, cpu_reset_out stays 1.
  - start_in then a valid 1-word frame -> error_out clears, done_out = 1.
- Valid gaps: random byte_valid_in deassertion between and within words of a 3-word load -> identical writes and addresses 0x0, 0x4, 0x8.
- Reset mid-load: assert reset_in low after 6 bytes of a 4-word load -> immediate IDLE, all outputs at reset values, no further strobes.
- Reload after done: start_in in DONE -> cpu_reset_out = 1 on the next cycle; a new 1-word load writes to BASE_ADDRESS again.

Source files
------------

// File: rtl/instr_loader.sv
// Boot-time instruction loader: assembles a byte stream into 32-bit words, writes them into
// the core's instruction memory and holds the core in reset until the image is complete.
module instr_loader #(
    parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0000,
    parameter int unsigned MAX_WORDS     = 256,
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     start_in,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid_in,
    output logic                     byte_ready_out,
    output logic                     instrWrite_out,
    output logic [ADDRESS_WIDTH-1:0] instr_address_out,
    output logic [31:0]              instr_out,
    output logic                     cpu_reset_out,
    output logic                     done_out,
    output logic                     error_out,
    output logic [15:0]              words_loaded_out
);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StData,
        StWrite,
        StDone,
        StError
    } state_e;

    localparam logic [ADDRESS_WIDTH-1:0] BaseAddr = ADDRESS_WIDTH'(BASE_ADDRESS);
    localparam logic [31:0]              MaxWords = 32'(MAX_WORDS);

    state_e                   state_q, state_d;
    logic [1:0]               byte_cnt_q, byte_cnt_d;
    logic [31:0]              count_q, count_d;
    logic [31:0]              word_q, word_d;
    logic [31:0]              instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]              words_q, words_d;

    logic        transfer;
    logic [31:0] count_shift;
    logic [31:0] word_shift;
    logic [15:0] words_inc;

    // Outputs are decoded from the state register only; no path from byte_valid_in.
    assign byte_ready_out    = (state_q == StCount) || (state_q == StData);
    assign instrWrite_out    = (state_q == StWrite);
    assign cpu_reset_out     = (state_q != StDone);
    assign done_out          = (state_q == StDone);
    assign error_out         = (state_q == StError);
    assign instr_address_out = addr_q;
    assign instr_out         = instr_q;
    assign words_loaded_out  = words_q;

    assign transfer    = byte_valid_in && byte_ready_out;
    assign count_shift = {count_q[23:0], byte_in};
    assign word_shift  = {word_q[23:0], byte_in};
    assign words_inc   = words_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        count_d    = count_q;
        word_d     = word_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        words_d    = words_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_in) begin
                    state_d    = StCount;
                    byte_cnt_d = 2'd0;
                    count_d    = 32'd0;
                    words_d    = 16'd0;
                    addr_d     = BaseAddr;
                end
            end
            StCount: begin
                if (transfer) begin
                    count_d    = count_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (count_shift == 32'd0) begin
                            state_d = StDone;
                        end else if (count_shift > MaxWords) begin
                            state_d = StError;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (transfer) begin
                    word_d     = word_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Address and data are captured once here and held through the strobe.
                        state_d = StWrite;
                        instr_d = word_shift;
                        addr_d  = BaseAddr + (ADDRESS_WIDTH'(words_q) << 2);
                    end
                end
            end
            StWrite: begin
                words_d = words_inc;
                state_d = ({16'd0, words_inc} == count_q) ? StDone : StData;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            byte_cnt_q <= 2'd0;
            count_q    <= 32'd0;
            word_q     <= 32'd0;
            instr_q    <= 32'd0;
            addr_q     <= BaseAddr;
            words_q    <= 16'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            count_q    <= count_d;
            word_q     <= word_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: frames are streamed byte by byte and every write strobe is
// logged and compared against hand-computed addresses and data.
module tb_instr_loader;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        start_in = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid_in = 1'b0;
    logic        byte_ready_out;
    logic        instrWrite_out;
    logic [31:0] instr_address_out;
    logic [31:0] instr_out;
    logic        cpu_reset_out;
    logic        done_out;
    logic        error_out;
    logic [15:0] words_loaded_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    always #5 clock_in = ~clock_in;

    instr_loader dut (
        .clock_in          (clock_in),
        .reset_in          (reset_in),
        .start_in          (start_in),
        .byte_in           (byte_in),
        .byte_valid_in     (byte_valid_in),
        .byte_ready_out    (byte_ready_out),
        .instrWrite_out    (instrWrite_out),
        .instr_address_out (instr_address_out),
        .instr_out         (instr_out),
        .cpu_reset_out     (cpu_reset_out),
        .done_out          (done_out),
        .error_out         (error_out),
        .words_loaded_out  (words_loaded_out)
    );

    always @(negedge clock_in) begin
        if (instrWrite_out) begin
            wr_addr.push_back(instr_address_out);
            wr_data.push_back(instr_out);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        byte_valid_in = 1'b0;
        repeat (gap) tick();
        byte_in       = b;
        byte_valid_in = 1'b1;
        @(negedge clock_in);
        while (!byte_ready_out && n < 50) begin
            @(negedge clock_in);
            n++;
        end
        if (!byte_ready_out) check("ready_timeout", 64'(byte_ready_out), 64'd1);
        @(posedge clock_in);
        #1;
        byte_valid_in = 1'b0;
    endtask

    task automatic send_count(input logic [31:0] n, input bit gaps);
        for (int i = 3; i >= 0; i--) begin
            send_byte(n[8*i +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    // Sends one word; the strobe must be visible right after the 4th byte is accepted.
    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gaps);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
        end
        check("strobe_latency", 64'(instrWrite_out), 64'd1);
        check("strobe_addr", 64'(instr_address_out), 64'(addr));
        check("strobe_data", 64'(instr_out), 64'(w));
        check("strobe_ready_low", 64'(byte_ready_out), 64'd0);
        check("strobe_core_held", 64'(cpu_reset_out), 64'd1);
        exp_addr.push_back(addr);
        exp_data.push_back(w);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, 64'(wr_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
            check({tag, "_addr"}, 64'(wr_addr[i]), 64'(exp_addr[i]));
            check({tag, "_data"}, 64'(wr_data[i]), 64'(exp_data[i]));
        end
        wr_addr.delete();
        wr_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(byte_ready_out), 64'd0);
        check({tag, "_wr"}, 64'(instrWrite_out), 64'd0);
        check({tag, "_addr"}, 64'(instr_address_out), 64'd0);
        check({tag, "_instr"}, 64'(instr_out), 64'd0);
        check({tag, "_cpurst"}, 64'(cpu_reset_out), 64'd1);
        check({tag, "_done"}, 64'(done_out), 64'd0);
        check({tag, "_err"}, 64'(error_out), 64'd0);
        check({tag, "_words"}, 64'(words_loaded_out), 64'd0);
    endtask

    initial begin
        // Reset, then idle for 20 cycles with no start.
        repeat (2) tick();
        check_reset_outputs("rst");
        reset_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_in);
            check("idle_cpurst", 64'(cpu_reset_out), 64'd1);
            check("idle_ready", 64'(byte_ready_out), 64'd0);
            check("idle_done", 64'(done_out), 64'd0);
        end
        tick();

        // Two-word load.
        pulse_start();
        check("count_ready", 64'(byte_ready_out), 64'd1);
        send_count(32'd2, 1'b0);
        send_word(32'h2008_0005, 32'h0, 1'b0);
        send_word(32'h8C09_0004, 32'h4, 1'b0);
        tick();
        check("two_done", 64'(done_out), 64'd1);
        check("two_cpurst", 64'(cpu_reset_out), 64'd0);
        check("two_words", 64'(words_loaded_out), 64'd2);
        check("two_ready", 64'(byte_ready_out), 64'd0);
        check_log("two");

        // Zero count goes straight to DONE; start in DONE reasserts core reset next cycle.
        pulse_start();
        check("restart_cpurst", 64'(cpu_reset_out), 64'd1);
        check("restart_done", 64'(done_out), 64'd0);
        check("restart_words", 64'(words_loaded_out), 64'd0);
        send_count(32'd0, 1'b0);
        check("zero_done", 64'(done_out), 64'd1);
        check("zero_cpurst", 64'(cpu_reset_out), 64'd0);
        check("zero_words", 64'(words_loaded_out), 64'd0);
        check_log("zero");

        // Overflow: 257 > MAX_WORDS.
        pulse_start();
        send_count(32'h0000_0101, 1'b0);
        check("ovf_err", 64'(error_out), 64'd1);
        check("ovf_cpurst", 64'(cpu_reset_out), 64'd1);
        check("ovf_done", 64'(done_out), 64'd0);
        check("ovf_ready", 64'(byte_ready_out), 64'd0);
        pulse_start();
        check("ovf_clear", 64'(error_out), 64'd0);
        send_count(32'd1, 1'b0);
        send_word(32'hDEAD_BEEF, 32'h0, 1'b0);
        tick();
        check("ovf_recover_done", 64'(done_out), 64'd1);
        check("ovf_recover_words", 64'(words_loaded_out), 64'd1);
        check_log("ovf");

        // N = MAX_WORDS is accepted; abort by reset afterwards.
        pulse_start();
        send_count(32'd256, 1'b0);
        check("max_err", 64'(error_out), 64'd0);
        check("max_ready", 64'(byte_ready_out), 64'd1);
        reset_in = 1'b0;
        #1;
        check_reset_outputs("max_rst");
        tick();
        reset_in = 1'b1;
        tick();

        // Three-word load with random valid gaps.
        pulse_start();
        send_count(32'd3, 1'b1);
        send_word(32'h0123_4567, 32'h0, 1'b1);
        send_word(32'h89AB_CDEF, 32'h4, 1'b1);
        send_word(32'hA5A5_5A5A, 32'h8, 1'b1);
        tick();
        check("gap_done", 64'(done_out), 64'd1);
        check("gap_words", 64'(words_loaded_out), 64'd3);
        check_log("gap");

        // Reset after 6 bytes of a 4-word load.
        pulse_start();
        send_count(32'd4, 1'b0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        byte_in       = 8'hAA;
        byte_valid_in = 1'b1;
        #2;
        reset_in = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (5) tick();
        check("midrst_hold_wr", 64'(instrWrite_out), 64'd0);
        reset_in = 1'b1;
        repeat (5) tick();
        byte_valid_in = 1'b0;
        check_reset_outputs("midrst_idle");
        check_log("midrst");

        // Reload after DONE writes from BASE_ADDRESS again.
        pulse_start();
        send_count(32'd1, 1'b0);
        send_word(32'hCAFE_F00D, 32'h0, 1'b0);
        tick();
        check("reload1_done", 64'(done_out), 64'd1);
        pulse_start();
        check("reload_cpurst", 64'(cpu_reset_out), 64'd1);
        check("reload_done_clr", 64'(done_out), 64'd0);
        send_count(32'd1, 1'b0);
        send_word(32'h1234_5678, 32'h0, 1'b0);
        tick();
        check("reload2_done", 64'(done_out), 64'd1);
        check("reload2_cpurst", 64'(cpu_reset_out), 64'd0);
        check("reload2_words", 64'(words_loaded_out), 64'd1);
        check_log("reload");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
